// File: rtl/regfile_dump.sv
// Debug read-out of the integer register file: halts the core, streams x0..x31 on valid/ready.
// Ports: clk/rst, start, halt_req/halt_ack, rf_ra/rf_rd, m_valid/m_ready/m_data/m_index/m_last, busy, done. Option: REGFILE_DUMP_PREFETCH_EN.
module regfile_dump #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic [ADDR_W-1:0] rf_ra,
  input  logic [DATA_W-1:0] rf_rd,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    HALT_WAIT,
    READ,
    SEND,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nx;
  logic              hs;

  assign idx_nx = idx + ADDR_W'(1);
  assign hs     = m_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      halt_req <= 1'b0;
      rf_ra    <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_index  <= '0;
      m_last   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= HALT_WAIT;
            halt_req <= 1'b1;
            busy     <= 1'b1;
            idx      <= '0;
            rf_ra    <= '0;
          end
        end
        HALT_WAIT: begin
          if (halt_ack) state <= READ;
        end
        READ: begin
          m_data  <= rf_rd;
          m_index <= idx;
          m_last  <= (idx == LAST);
          m_valid <= 1'b1;
          state   <= SEND;
`ifdef REGFILE_DUMP_PREFETCH_EN
          // point the port at the next word so it is ready at the handshake
          if (idx != LAST) rf_ra <= idx_nx;
`endif
        end
        SEND: begin
          if (hs) begin
            if (idx == LAST) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
`ifdef REGFILE_DUMP_PREFETCH_EN
              m_data  <= rf_rd;
              m_index <= idx_nx;
              m_last  <= (idx_nx == LAST);
              idx     <= idx_nx;
              if (idx_nx != LAST) rf_ra <= idx_nx + ADDR_W'(1);
`else
              idx     <= idx_nx;
              rf_ra   <= idx_nx;
              m_valid <= 1'b0;
              state   <= READ;
`endif
            end
          end
        end
        DONE: begin
          halt_req <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: table of dump scenarios plus reset-mid-dump sequence.
// Register file modelled as xN = 0xA5000000+N with x0 reading zero.
module tb_regfile_dump;

`ifdef REGFILE_DUMP_PREFETCH_EN
  localparam int BASE = 35;
`else
  localparam int BASE = 66;
`endif

  logic        clk = 0;
  logic        rst;
  logic        start;
  logic        halt_req;
  logic        halt_ack;
  logic [4:0]  rf_ra;
  logic [31:0] rf_rd;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [4:0]  m_index;
  logic        m_last;
  logic        busy;
  logic        done;

  logic [31:0] rf_mem [32];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rf_rd = (rf_ra == 5'd0) ? 32'h0 : rf_mem[rf_ra];

  regfile_dump dut (
    .clk(clk), .rst(rst), .start(start),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .rf_ra(rf_ra), .rf_rd(rf_rd),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_index(m_index), .m_last(m_last),
    .busy(busy), .done(done)
  );

  typedef struct {
    int halt_dly;
    int stall_len;
    bit restart;
    bit rand_rdy;
    int exp_cyc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " halt_req"}, 32'(halt_req), 0);
    chk({tag, " rf_ra"}, 32'(rf_ra), 0);
    chk({tag, " m_valid"}, 32'(m_valid), 0);
    chk({tag, " m_data"}, m_data, 0);
    chk({tag, " m_index"}, 32'(m_index), 0);
    chk({tag, " m_last"}, 32'(m_last), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
  endtask

  task automatic run_dump(input vec_t v);
    int cyc, nw, nlast, stall_left, first_v;
    logic pv, pl;
    logic [31:0] pd, expd;
    logic [4:0] pi;
    bit fin;
    cyc = 0; nw = 0; nlast = 0; first_v = -1;
    stall_left = v.stall_len; pv = 0; fin = 0;
    pd = '0; pi = '0; pl = 0;
    @(negedge clk);
    start = 1;
    halt_ack = (v.halt_dly == 0);
    m_ready = 1;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 0;
      m_ready = 1;
      chk("busy", 32'(busy), 1);
      chk("halt_req", 32'(halt_req), 1);
      if (v.halt_dly > 0 && cyc <= v.halt_dly + 1) begin
        chk("wait m_valid", 32'(m_valid), 0);
        chk("wait rf_ra", 32'(rf_ra), 0);
        if (cyc == v.halt_dly + 1) halt_ack = 1;
      end
      if (pv) begin
        chk("hold valid", 32'(m_valid), 1);
        chk("hold data", m_data, pd);
        chk("hold index", 32'(m_index), 32'(pi));
        chk("hold last", 32'(m_last), 32'(pl));
      end
      pv = 0;
      if (m_valid) begin
        if (first_v < 0) begin
          first_v = cyc;
          chk("first word cycle", 32'(cyc), 32'(v.halt_dly + 3));
          if (v.halt_dly > 0) halt_ack = 0;
        end
        if (nw == 7 && stall_left > 0) begin
          m_ready = 0;
          stall_left--;
        end else if (v.rand_rdy) begin
          m_ready = 1'($urandom_range(0, 1));
        end
        if (v.restart && nw == 3) start = 1;
        if (m_ready) begin
          expd = (nw == 0) ? 32'h0 : 32'hA500_0000 + 32'(nw);
          chk("word index", 32'(m_index), 32'(nw));
          chk("word data", m_data, expd);
          chk("word last", 32'(m_last), 32'(nw == 31));
          if (m_last) nlast++;
          nw++;
        end else begin
          pv = 1; pd = m_data; pi = m_index; pl = m_last;
        end
      end
      if (done) begin
        fin = 1;
        chk("word count", 32'(nw), 32);
        chk("last count", 32'(nlast), 1);
        if (v.exp_cyc > 0) chk("dump cycles", 32'(cyc), 32'(v.exp_cyc));
        if (v.restart) start = 1;
      end
    end
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got no done after %0d cycles, required done", cyc);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 0;
      chk("post done", 32'(done), 0);
      chk("post busy", 32'(busy), 0);
      chk("post halt_req", 32'(halt_req), 0);
      chk("post m_valid", 32'(m_valid), 0);
    end
  endtask

  initial begin
    int c;
    for (int n = 0; n < 32; n++) rf_mem[n] = 32'hA500_0000 + 32'(n);
    vecs[0] = '{0, 0, 0, 0, BASE};
    vecs[1] = '{10, 0, 0, 0, BASE + 10};
    vecs[2] = '{0, 5, 0, 0, BASE + 5};
    vecs[3] = '{0, 0, 1, 0, BASE};
    vecs[4] = '{0, 0, 0, 1, -1};
    vecs[5] = '{0, 0, 0, 1, -1};
    vecs[6] = '{0, 0, 0, 1, -1};

    rst = 1; start = 0; halt_ack = 1; m_ready = 1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 0;

    for (int i = 0; i < 7; i++) run_dump(vecs[i]);

    // reset while word 12 is on the stream
    @(negedge clk);
    start = 1; halt_ack = 1; m_ready = 1;
    @(negedge clk);
    start = 0;
    c = 0;
    while (!(m_valid && m_index == 5'd12) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("reach index 12", 32'(m_index), 12);
    #2 rst = 1;
    #1 chk_zero("async rst");
    @(negedge clk);
    rst = 0;
    run_dump(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
